// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the configurable UART blocks: parity mode
//   encodings, the transmitter FSM state encoding and default parameters.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int unsigned DEFAULT_CLK_DIV = 434;  // 50 MHz / 115200
   localparam int unsigned DEFAULT_DATA_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Bit-period counter. Counts 0..CLK_DIV-1 and wraps; tick_o is high on the
//   last cycle of every bit period.
//   clk_i  : clock
//   rst_i  : asynchronous, active-high reset
//   clr_i  : holds the counter at zero (restarts the bit period)
//   tick_o : bit-boundary tick
module uart_baud_gen #(
   parameter int unsigned CLK_DIV = 434
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   UART transmitter with valid/ready input, per-frame parity mode and
//   stop-bit count, LSB-first data of DATA_W bits, CLK_DIV clocks per bit.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   data_i       : frame payload
//   valid_i      : payload valid; accepted when ready_o is high
//   ready_o      : high only in IDLE
//   par_mode_i   : 00 none, 01 even, 10 odd, 11 none
//   stop2_i      : 0 one stop bit, 1 two stop bits
//   tx_o         : registered serial line, idles high
//   busy_o       : frame in progress
//   eot_o        : one-cycle pulse on the last cycle of the final stop bit
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [1:0]        par_mode_i,
   input  logic              stop2_i,
   output logic              tx_o,
   output logic              busy_o,
   output logic              eot_o
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              par_en_q, par_en_d;
   logic              par_bit_q, par_bit_d;
   logic              stop2_q, stop2_d;
   logic              tx_q, tx_d;
   logic              eot_q, eot_d;
   logic              tick;

   // Counter is held at zero while idle, so it restarts exactly on accept.
   uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (state_q == ST_IDLE),
      .tick_o (tick)
   );

   assign ready_o = (state_q == ST_IDLE);
   assign busy_o  = (state_q != ST_IDLE);
   assign tx_o    = tx_q;
   assign eot_o   = eot_q;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      eot_d     = 1'b0;
      tx_d      = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (valid_i) begin
               shift_d   = data_i;
               par_en_d  = (par_mode_i == PAR_EVEN) || (par_mode_i == PAR_ODD);
               par_bit_d = (par_mode_i == PAR_ODD) ? ~^data_i : ^data_i;
               stop2_d   = stop2_i;
               bit_cnt_d = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            tx_d = 1'b0;
            if (tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            tx_d = shift_q[0];
            if (tick) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            tx_d = par_bit_q;
            if (tick) state_d = ST_STOP;
         end
         ST_STOP: begin
            tx_d = 1'b1;
            // bit_cnt is reused to count the first of two stop bits.
            if (tick) begin
               if (stop2_q && (bit_cnt_q == '0)) begin
                  bit_cnt_d = BIT_W'(1);
               end else begin
                  bit_cnt_d = '0;
                  eot_d     = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
         eot_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
         tx_q      <= tx_d;
         eot_q     <= eot_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg
//   Directed bench for uart_tx_cfg with DATA_W=8, CLK_DIV=4. Cycle k is the
//   value observed 1 time unit after the k-th rising edge following accept.
module tb_uart_tx_cfg;

   localparam int unsigned DIV = 4;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [7:0] data_i = '0;
   logic       valid_i = 1'b0;
   logic       ready_o;
   logic [1:0] par_mode_i = '0;
   logic       stop2_i = 1'b0;
   logic       tx_o;
   logic       busy_o;
   logic       eot_o;

   int errors = 0;
   int checks = 0;
   int eot_cnt = 0;
   logic scramble = 1'b0;

   uart_tx_cfg #(.DATA_W(8), .CLK_DIV(DIV)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .par_mode_i (par_mode_i),
      .stop2_i    (stop2_i),
      .tx_o       (tx_o),
      .busy_o     (busy_o),
      .eot_o      (eot_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (eot_o === 1'b1) eot_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one accept; returns 1 after the accept edge (cycle 0).
   task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic s2, input logic hold);
      @(negedge clk_i);
      chk("ready_before_accept", 32'(ready_o), 32'd1);
      data_i = d; par_mode_i = pm; stop2_i = s2; valid_i = 1'b1;
      @(posedge clk_i); #1;
      if (!hold) valid_i = 1'b0;
      chk("ready_after_accept", 32'(ready_o), 32'd0);
   endtask

   // Checks cycles 1..N of a frame against the expected waveform.
   task automatic check_frame(input string tag, input logic [7:0] d, input logic pen,
                              input logic pbit, input logic s2);
      int unsigned n;
      n = (1 + 8 + (pen ? 1 : 0) + (s2 ? 2 : 1)) * DIV;
      for (int unsigned k = 1; k <= n; k++) begin
         int unsigned idx;
         logic exp;
         @(posedge clk_i); #1;
         idx = (k - 1) / DIV;
         if (idx == 0) exp = 1'b0;
         else if (idx <= 8) exp = d[idx-1];
         else if (pen && idx == 9) exp = pbit;
         else exp = 1'b1;
         chk({tag, "_tx"}, 32'(tx_o), 32'(exp));
         chk({tag, "_eot"}, 32'(eot_o), 32'(k == n));
         if (k < n) chk({tag, "_busy"}, 32'(busy_o), 32'd1);
         if (scramble) begin
            data_i = 8'($urandom); par_mode_i = 2'($urandom); stop2_i = 1'($urandom);
         end
      end
   endtask

   initial begin
      int e0;
      // Reset state
      #12;
      chk("rst_tx", 32'(tx_o), 32'd1);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_eot", 32'(eot_o), 32'd0);
      @(negedge clk_i); rst_i = 1'b0;

      // 0x55, no parity, 1 stop: eot at 40, ready at 41
      send(8'h55, 2'b00, 1'b0, 1'b0);
      check_frame("f55", 8'h55, 1'b0, 1'b0, 1'b0);
      @(posedge clk_i); #1;
      chk("f55_ready41", 32'(ready_o), 32'd1);
      chk("f55_tx41", 32'(tx_o), 32'd1);

      // Parity cases (hand-computed parity bits), eot at 44
      send(8'h07, 2'b01, 1'b0, 1'b0);
      check_frame("p07e", 8'h07, 1'b1, 1'b1, 1'b0);
      send(8'h03, 2'b01, 1'b0, 1'b0);
      check_frame("p03e", 8'h03, 1'b1, 1'b0, 1'b0);
      send(8'h03, 2'b10, 1'b0, 1'b0);
      check_frame("p03o", 8'h03, 1'b1, 1'b1, 1'b0);

      // Mode 11 treated as none, two stop bits, eot at 44
      send(8'hA5, 2'b11, 1'b1, 1'b0);
      check_frame("fA5", 8'hA5, 1'b0, 1'b0, 1'b1);

      // Back-to-back with valid held high
      send(8'h12, 2'b00, 1'b0, 1'b1);
      data_i = 8'h34;
      check_frame("b2b_12", 8'h12, 1'b0, 1'b0, 1'b0);
      @(posedge clk_i); #1;                // cycle 41: second accept edge
      valid_i = 1'b0;
      chk("b2b_accept41", 32'(ready_o), 32'd0);
      chk("b2b_mark41", 32'(tx_o), 32'd1);
      check_frame("b2b_34", 8'h34, 1'b0, 1'b0, 1'b0);
      @(posedge clk_i); #1;
      chk("b2b_no_dup", 32'(busy_o), 32'd0);

      // Reset during data bit 3 of 0xF0 (cycles 17..20)
      send(8'hF0, 2'b00, 1'b0, 1'b0);
      repeat (18) @(posedge clk_i);
      #1;
      chk("rst_mid_tx_before", 32'(tx_o), 32'd0);
      e0 = eot_cnt;
      #2 rst_i = 1'b1;
      #1;
      chk("rst_mid_tx", 32'(tx_o), 32'd1);
      chk("rst_mid_ready", 32'(ready_o), 32'd1);
      chk("rst_mid_busy", 32'(busy_o), 32'd0);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i); rst_i = 1'b0;
      repeat (30) @(posedge clk_i);
      #1;
      chk("rst_mid_no_eot", 32'(eot_cnt - e0), 32'd0);
      chk("rst_mid_idle_tx", 32'(tx_o), 32'd1);
      send(8'h0F, 2'b00, 1'b0, 1'b0);
      check_frame("f0F", 8'h0F, 1'b0, 1'b0, 1'b0);

      // Mid-frame input changes must not alter the frame (0x3C, odd -> 1, 2 stop)
      send(8'h3C, 2'b10, 1'b1, 1'b0);
      scramble = 1'b1;
      check_frame("scr3C", 8'h3C, 1'b1, 1'b1, 1'b1);
      scramble = 1'b0;
      @(posedge clk_i); #1;
      chk("scr_idle", 32'(ready_o), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
